// File: rtl/ffn_pkg.sv
// Shared types and default sizing for the weight feeder path
// between weight_buffer and the systolic array.
package ffn_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int MEM_LEN    = 16;
  localparam int ADDR_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } feeder_state_t;

  typedef logic [DATA_WIDTH-1:0] weight_t;
endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage data+valid shift register; DEPTH=0 passes straight through.
// Used once per lane to build the diagonal weight skew.
module skew_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             v,
  output logic [WIDTH-1:0] q,
  output logic             qv
);
  localparam int N = (DEPTH > 0) ? DEPTH : 1;

  logic [WIDTH:0] sr [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) sr[i] <= '0;
    end else begin
      sr[0] <= {v, d};
      for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
    end
  end

  assign {qv, q} = (DEPTH == 0) ? {v, d} : sr[N-1];
endmodule

// File: rtl/weight_feeder.sv
// Streams COUNT weight_buffer rows into the systolic array,
// skewing lane j by j cycles so weights arrive wavefront-aligned.
module weight_feeder #(
  parameter int DATA_WIDTH = ffn_pkg::DATA_WIDTH,
  parameter int MEM_LEN    = ffn_pkg::MEM_LEN,
  parameter int ADDR_W     = ffn_pkg::ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [ADDR_W-1:0]             base_addr_i,
  input  logic [ADDR_W:0]               count_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          rd_en_o,
  output logic [ADDR_W-1:0]             rd_addr_o,
  input  logic [DATA_WIDTH*MEM_LEN-1:0] rd_data_i,
  output logic [DATA_WIDTH*MEM_LEN-1:0] w_o,
  output logic [MEM_LEN-1:0]            w_valid_o
);
  import ffn_pkg::*;

  localparam int DCW = $clog2(MEM_LEN + 1);
  localparam logic [DCW-1:0] DLAST = DCW'(MEM_LEN);

  feeder_state_t state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   rows;
  logic [ADDR_W:0]   rows_nx;
  logic [ADDR_W:0]   cnt;
  logic [DCW-1:0]    dcnt;

  assign rows_nx = rows + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      rows  <= '0;
      cnt   <= '0;
      dcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: if (start_i) begin
          addr  <= base_addr_i;
          cnt   <= count_i;
          rows  <= '0;
          dcnt  <= '0;
          state <= (count_i == '0) ? DONE : READ;
        end
        READ: begin
          addr <= addr + 1'b1;
          rows <= rows_nx;
          if (rows_nx == cnt) state <= DRAIN;
        end
        // Hold off done until the farthest lane has shifted out its last row
        DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (dcnt == DLAST) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);
  assign rd_en_o   = (state == READ);
  assign rd_addr_o = addr;

  logic                          rd_en_q;
  logic                          cap_v;
  logic [DATA_WIDTH*MEM_LEN-1:0] cap_d;

  // Buffer data is only meaningful the cycle after a read was issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_q <= 1'b0;
      cap_v   <= 1'b0;
      cap_d   <= '0;
    end else begin
      rd_en_q <= rd_en_o;
      cap_v   <= rd_en_q;
      cap_d   <= rd_en_q ? rd_data_i : '0;
    end
  end

  for (genvar j = 0; j < MEM_LEN; j++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_d;
    logic                  lane_v;

    skew_delay_line #(
      .WIDTH(DATA_WIDTH),
      .DEPTH(j)
    ) u_skew (
      .clk(clk),
      .rst(rst),
      .d  (cap_d[j*DATA_WIDTH +: DATA_WIDTH]),
      .v  (cap_v),
      .q  (lane_d),
      .qv (lane_v)
    );

    assign w_valid_o[j] = lane_v;
    assign w_o[j*DATA_WIDTH +: DATA_WIDTH] = lane_v ? lane_d : '0;
  end
endmodule

// File: tb/tb_weight_feeder.sv
// Self-checking bench for weight_feeder: table jobs, reset abort,
// spurious starts and random jobs against a per-cycle timeline model.
module tb_weight_feeder;
  import ffn_pkg::*;

  localparam int DW = 16;
  localparam int ML = 16;
  localparam int AW = 4;
  localparam int NC = 64;

  logic            clk = 0;
  logic            rst = 1;
  logic            start_i = 0;
  logic [AW-1:0]   base_addr_i = '0;
  logic [AW:0]     count_i = '0;
  logic            busy_o, done_o, rd_en_o;
  logic [AW-1:0]   rd_addr_o;
  logic [DW*ML-1:0] rd_data_i;
  logic [DW*ML-1:0] w_o;
  logic [ML-1:0]   w_valid_o;

  int n_chk = 0;
  int n_fail = 0;

  weight_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .count_i    (count_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rd_en_o    (rd_en_o),
    .rd_addr_o  (rd_addr_o),
    .rd_data_i  (rd_data_i),
    .w_o        (w_o),
    .w_valid_o  (w_valid_o)
  );

  always #5 clk = ~clk;

  // Buffer model: 1-cycle read latency, junk on the bus when not reading
  logic [DW-1:0] mem [16][16];
  always @(posedge clk) begin
    for (int j = 0; j < ML; j++)
      rd_data_i[j*DW +: DW] <= rd_en_o ? mem[rd_addr_o][j] : DW'($urandom);
  end

  // Expected per-cycle timeline of one job, cycle 0 = start cycle
  bit            e_rd   [NC];
  int            e_addr [NC];
  logic [255:0]  e_w    [NC];
  logic [ML-1:0] e_v    [NC];
  bit            e_busy [NC];
  bit            e_done [NC];
  int            e_len;

  task automatic build(input int b, input int n);
    for (int c = 0; c < NC; c++) begin
      e_rd[c] = 0; e_addr[c] = 0; e_w[c] = '0;
      e_v[c] = '0; e_busy[c] = 0; e_done[c] = 0;
    end
    e_len = (n > 0) ? n + ML + 2 : 1;
    for (int k = 0; k < n; k++) begin
      int t;
      int r;
      t = 1 + k;
      r = (b + k) % 16;
      e_rd[t] = 1;
      e_addr[t] = r;
      for (int j = 0; j < ML; j++) begin
        e_v[t+2+j][j] = 1'b1;
        e_w[t+2+j][j*DW +: DW] = mem[r][j];
      end
    end
    for (int c = 1; c <= e_len; c++) e_busy[c] = 1;
    e_done[e_len] = 1;
  endtask

  task automatic chk(input string nm, input int c,
                     input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  task automatic check_cycle(input int c);
    chk("rd_en", c, 256'(rd_en_o), 256'(e_rd[c]));
    if (e_rd[c]) chk("rd_addr", c, 256'(rd_addr_o), 256'(e_addr[c]));
    chk("w_valid", c, 256'(w_valid_o), 256'(e_v[c]));
    chk("w", c, w_o, e_w[c]);
    chk("busy", c, 256'(busy_o), 256'(e_busy[c]));
    chk("done", c, 256'(done_o), 256'(e_done[c]));
  endtask

  // Job starts in the cycle of the first negedge; spurious starts are
  // pulsed mid-READ and in the DONE cycle when spur is set.
  task automatic run_job(input int b, input int n, input bit spur, input int want_done);
    int first_done;
    first_done = -1;
    build(b, n);
    for (int c = 0; c <= e_len; c++) begin
      @(negedge clk);
      check_cycle(c);
      if (done_o && first_done < 0) first_done = c;
      start_i = (c == 0) || (spur && ((c == 2 && n >= 3) || c == e_len));
      base_addr_i = (c == 0) ? AW'(b) : AW'($urandom);
      count_i = (c == 0) ? (AW+1)'(n) : (AW+1)'($urandom_range(1, 16));
    end
    chk("done_cycle", want_done, 256'(first_done), 256'(want_done));
  endtask

  typedef struct {
    int base;
    int cnt;
    bit spur;
    int done_cyc;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int seen_done;
    int seen_act;

    tbl[0] = '{base: 5,  cnt: 1,  spur: 0, done_cyc: 19};
    tbl[1] = '{base: 0,  cnt: 16, spur: 0, done_cyc: 34};
    tbl[2] = '{base: 14, cnt: 4,  spur: 0, done_cyc: 22};
    tbl[3] = '{base: 0,  cnt: 0,  spur: 0, done_cyc: 1};
    tbl[4] = '{base: 7,  cnt: 8,  spur: 1, done_cyc: 26};
    tbl[5] = '{base: 2,  cnt: 3,  spur: 1, done_cyc: 21};

    for (int r = 0; r < 16; r++)
      for (int j = 0; j < ML; j++)
        mem[r][j] = DW'((r << 8) | j);
    for (int j = 0; j < ML; j++) mem[5][j] = DW'(j);

    repeat (3) @(negedge clk);
    chk("reset_busy", 0, 256'(busy_o), 256'(0));
    chk("reset_outs", 0, {w_o[239:0], w_valid_o},
        256'(0));
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_job(tbl[i].base, tbl[i].cnt, tbl[i].spur, tbl[i].done_cyc);
    @(negedge clk);
    start_i = 0;

    // Abort mid-READ: base 3, count 8, reset asserted in cycle 3
    @(negedge clk);
    start_i = 1; base_addr_i = 4'd3; count_i = 5'd8;
    @(negedge clk);
    start_i = 0;
    repeat (2) @(negedge clk);
    chk("pre_abort_rd_en", 3, 256'(rd_en_o), 256'(1));
    rst = 1;
    @(negedge clk);
    chk("abort_rd_en", 4, 256'(rd_en_o), 256'(0));
    chk("abort_addr", 4, 256'(rd_addr_o), 256'(0));
    chk("abort_busy", 4, 256'(busy_o), 256'(0));
    chk("abort_done", 4, 256'(done_o), 256'(0));
    chk("abort_w", 4, w_o, 256'(0));
    chk("abort_valid", 4, 256'(w_valid_o), 256'(0));
    rst = 0;
    seen_done = 0;
    seen_act = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done_o) seen_done++;
      if (busy_o || rd_en_o || (w_valid_o != '0)) seen_act++;
    end
    chk("abort_no_done", 0, 256'(seen_done), 256'(0));
    chk("abort_quiet", 0, 256'(seen_act), 256'(0));
    run_job(3, 8, 0, 26);

    // Random jobs with random buffer contents
    for (int r = 0; r < 16; r++)
      for (int j = 0; j < ML; j++)
        mem[r][j] = DW'($urandom);
    for (int i = 0; i < 8; i++) begin
      int b;
      int n;
      b = $urandom_range(0, 15);
      n = $urandom_range(0, 16);
      run_job(b, n, 1'($urandom), (n > 0) ? n + ML + 2 : 1);
    end
    @(negedge clk);
    start_i = 0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
